blob_selector: RTL

- Downstream of blob_extraction.
- Once blob_extraction_done is high, walks the blob record list that blob_extraction left in main memory.
- For each colour slot, keeps the largest blob whose pixel count is at or above a minimum. Exposes the winners through a registered query port for the tracking/servo logic.
- Shares the main-memory port with the other pipeline stages. Read-only: wren is always 0.

---
 rtl/falcon_blob_pkg.sv | 31 +++
 rtl/blob_slot_table.sv | 109 ++++++++++
 rtl/blob_selector.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/falcon_blob_pkg.sv
// Shared definitions for the blob pipeline stages:
// record layout in main memory and selector FSM encoding.
package falcon_blob_pkg;

    localparam int PIXCNT_MSB = 31;
    localparam int PIXCNT_LSB = 16;
    localparam int SLOT_MSB   = 4;
    localparam int SLOT_LSB   = 0;
    localparam int X_MSB      = 31;
    localparam int X_LSB      = 16;
    localparam int Y_MSB      = 15;
    localparam int Y_LSB      = 0;

    localparam int BLOB_RECORD_WORDS = 2;

    localparam int SLOT_W  = SLOT_MSB - SLOT_LSB + 1;
    localparam int CNT_W   = PIXCNT_MSB - PIXCNT_LSB + 1;
    localparam int COORD_W = X_MSB - X_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FETCH0  = 3'd2,
        ST_WAIT0   = 3'd3,
        ST_FETCH1  = 3'd4,
        ST_WAIT1   = 3'd5,
        ST_COMPARE = 3'd6,
        ST_DONE    = 3'd7
    } sel_state_e;

endpackage

// File: rtl/blob_slot_table.sv
// Per-colour winner table: clear, qualified update and a
// registered query read port.
module blob_slot_table
    import falcon_blob_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               upd_en,
    input  logic [SLOT_W-1:0]  upd_slot,
    input  logic [CNT_W-1:0]   upd_count,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic [CNT_W-1:0]   min_count,
    input  logic [SLOT_W-1:0]  query_slot,
    output logic               query_valid,
    output logic [CNT_W-1:0]   query_pixel_count,
    output logic [COORD_W-1:0] query_x,
    output logic [COORD_W-1:0] query_y
);

    logic               valid_q [NUM_SLOTS];
    logic [CNT_W-1:0]   cnt_q   [NUM_SLOTS];
    logic [COORD_W-1:0] x_q     [NUM_SLOTS];
    logic [COORD_W-1:0] y_q     [NUM_SLOTS];

    logic             cur_valid;
    logic [CNT_W-1:0] cur_cnt;
    logic             in_range;
    logic             take;

    logic               q_valid_d;
    logic [CNT_W-1:0]   q_cnt_d;
    logic [COORD_W-1:0] q_x_d;
    logic [COORD_W-1:0] q_y_d;

    // Look up the current holder of the candidate's slot and decide
    // whether the candidate displaces it (strictly larger wins).
    always_comb begin
        cur_valid = 1'b0;
        cur_cnt   = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (upd_slot == SLOT_W'(s)) begin
                cur_valid = valid_q[s];
                cur_cnt   = cnt_q[s];
            end
        end
        in_range = ({1'b0, upd_slot} < (SLOT_W + 1)'(NUM_SLOTS));
        take = upd_en && in_range && (upd_count >= min_count) &&
               (!cur_valid || (upd_count > cur_cnt));
    end

    // Table storage: clear wins over update, reset wipes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                valid_q[s] <= 1'b0;
                cnt_q[s]   <= '0;
                x_q[s]     <= '0;
                y_q[s]     <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (clear) begin
                    valid_q[s] <= 1'b0;
                end else if (take && (upd_slot == SLOT_W'(s))) begin
                    valid_q[s] <= 1'b1;
                    cnt_q[s]   <= upd_count;
                    x_q[s]     <= upd_x;
                    y_q[s]     <= upd_y;
                end
            end
        end
    end

    // Query mux; out-of-range slots read back as empty.
    always_comb begin
        q_valid_d = 1'b0;
        q_cnt_d   = '0;
        q_x_d     = '0;
        q_y_d     = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (query_slot == SLOT_W'(s) && valid_q[s]) begin
                q_valid_d = 1'b1;
                q_cnt_d   = cnt_q[s];
                q_x_d     = x_q[s];
                q_y_d     = y_q[s];
            end
        end
    end

    // Registered query port, one cycle behind query_slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            query_valid       <= 1'b0;
            query_pixel_count <= '0;
            query_x           <= '0;
            query_y           <= '0;
        end else begin
            query_valid       <= q_valid_d;
            query_pixel_count <= q_cnt_d;
            query_x           <= q_x_d;
            query_y           <= q_y_d;
        end
    end

endmodule

// File: rtl/blob_selector.sv
// Scans the blob record list and keeps the largest qualifying
// blob per colour slot for the tracking logic.
module blob_selector
    import falcon_blob_pkg::*;
#(
    parameter logic [17:0] BLOB_BASE_ADDR = 18'h30000,
    parameter int          NUM_SLOTS      = 8,
    parameter int          MAX_BLOBS      = 1024,
    parameter int          READ_LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_blob_selection,
    input  logic        pause,
    input  logic [15:0] blob_count,
    input  logic [15:0] min_pixel_count,
    input  logic [31:0] data_read,
    output logic        wren,
    output logic [17:0] address,
    output logic        blob_selection_done,
    input  logic [4:0]  query_slot,
    output logic        query_valid,
    output logic [15:0] query_pixel_count,
    output logic [15:0] query_x,
    output logic [15:0] query_y
);

    localparam int              WC_W      = $clog2(READ_LATENCY + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(READ_LATENCY);
    localparam logic [15:0]     N_CAP     = 16'(MAX_BLOBS);

    sel_state_e state_q, state_d;

    logic [15:0]        idx_q, idx_d;
    logic [15:0]        n_q, n_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [17:0]        addr_q, addr_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   pix_q, pix_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [15:0]        idx_next;

    logic tbl_clear;
    logic tbl_upd;

    // Word0 bits between the slot and pixel count fields are reserved.
    logic unused_w0_bits;
    assign unused_w0_bits = ^data_read[PIXCNT_LSB-1:SLOT_MSB+1];

    function automatic logic [17:0] rec_addr(input logic [15:0] idx);
        return BLOB_BASE_ADDR + 18'(BLOB_RECORD_WORDS) * 18'(idx);
    endfunction

    assign idx_next = idx_q + 16'd1;

    // Next-state logic: enable drop aborts, pause freezes, else scan.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        done_d    = done_q;
        pix_d     = pix_q;
        slot_d    = slot_q;
        x_d       = x_q;
        y_d       = y_q;
        tbl_clear = 1'b0;
        tbl_upd   = 1'b0;
        if (state_q != ST_IDLE && !enable_blob_selection) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            addr_d  = '0;
        end else if (!pause) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable_blob_selection) begin
                        state_d = ST_CLEAR;
                        n_d     = (blob_count > N_CAP) ? N_CAP : blob_count;
                        idx_d   = '0;
                        addr_d  = rec_addr('0);
                    end
                end
                ST_CLEAR: begin
                    tbl_clear = 1'b1;
                    if (n_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH0;
                        addr_d  = rec_addr(idx_q);
                    end
                end
                ST_FETCH0: begin
                    state_d = ST_WAIT0;
                    wcnt_d  = '0;
                end
                ST_WAIT0: begin
                    if (wcnt_q == WAIT_LAST) begin
                        state_d = ST_FETCH1;
                        pix_d   = data_read[PIXCNT_MSB:PIXCNT_LSB];
                        slot_d  = data_read[SLOT_MSB:SLOT_LSB];
                        addr_d  = addr_q + 18'd1;
                    end else begin
                        wcnt_d = wcnt_q + WC_W'(1);
                    end
                end
                ST_FETCH1: begin
                    state_d = ST_WAIT1;
                    wcnt_d  = '0;
                end
                ST_WAIT1: begin
                    if (wcnt_q == WAIT_LAST) begin
                        state_d = ST_COMPARE;
                        x_d     = data_read[X_MSB:X_LSB];
                        y_d     = data_read[Y_MSB:Y_LSB];
                    end else begin
                        wcnt_d = wcnt_q + WC_W'(1);
                    end
                end
                ST_COMPARE: begin
                    tbl_upd = 1'b1;
                    idx_d   = idx_next;
                    if (idx_next == n_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH0;
                        addr_d  = rec_addr(idx_next);
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            pix_q   <= '0;
            slot_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
            slot_q  <= slot_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    blob_slot_table #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_table (
        .clk               (clk),
        .reset             (reset),
        .clear             (tbl_clear),
        .upd_en            (tbl_upd),
        .upd_slot          (slot_q),
        .upd_count         (pix_q),
        .upd_x             (x_q),
        .upd_y             (y_q),
        .min_count         (min_pixel_count),
        .query_slot        (query_slot),
        .query_valid       (query_valid),
        .query_pixel_count (query_pixel_count),
        .query_x           (query_x),
        .query_y           (query_y)
    );

    assign wren                = 1'b0;
    assign address             = addr_q;
    assign blob_selection_done = done_q;

endmodule
